// File: rtl/branch_pred_if.sv
// Signal bundle between the pipeline and branch_pred_unit: decode/execute
// qualifiers in, fetch PC, flushes, prediction and statistics out.
interface branch_pred_if #(
  parameter int XLEN = 32
);
  logic            stallF;
  logic            stallD;
  logic            valid_d;
  logic            is_branch_d;
  logic            is_jal_d;
  logic            is_jalr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] imm_d;
  logic [2:0]      func3_d;
  logic            V;
  logic            Z;
  logic            C;
  logic            N;
  logic [XLEN-1:0] rs1_e;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus4_o;
  logic            flushD_o;
  logic            flushE_o;
  logic            pred_taken_d_o;
  logic [31:0]     branch_cnt_o;
  logic [31:0]     mispred_cnt_o;

  modport slave (
    input  stallF, stallD, valid_d, is_branch_d, is_jal_d, is_jalr_d,
    input  pc_d, imm_d, func3_d, V, Z, C, N, rs1_e,
    output pc_o, pc_plus4_o, flushD_o, flushE_o, pred_taken_d_o,
    output branch_cnt_o, mispred_cnt_o
  );

  modport master (
    output stallF, stallD, valid_d, is_branch_d, is_jal_d, is_jalr_d,
    output pc_d, imm_d, func3_d, V, Z, C, N, rs1_e,
    input  pc_o, pc_plus4_o, flushD_o, flushE_o, pred_taken_d_o,
    input  branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_pred_unit.sv
// Fetch PC generator with a 2-bit saturating-counter BHT: predicts at decode,
// resolves conditional branches and JALR in execute, keeps branch statistics.
module branch_pred_unit #(
  parameter int              XLEN        = 32,
  parameter int              BHT_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter bit              PREDICT_EN  = 1'b1
) (
  input logic          clk,
  input logic          rst_ni,
  branch_pred_if.slave bus
);

  localparam int              IDX  = $clog2(BHT_ENTRIES);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0]          fetch_pc_q, fetch_pc_d;
  logic [2*BHT_ENTRIES-1:0] bht_q, bht_d;

  logic                     e_valid_q, e_valid_d;
  logic                     e_branch_q, e_branch_d;
  logic                     e_jalr_q, e_jalr_d;
  logic [2:0]               e_func3_q, e_func3_d;
  logic                     e_pred_q, e_pred_d;
  logic [IDX-1:0]           e_idx_q, e_idx_d;
  logic [XLEN-1:0]          e_pc_q, e_pc_d;
  logic [XLEN-1:0]          e_imm_q, e_imm_d;

  logic [31:0]              branch_cnt_q, branch_cnt_d;
  logic [31:0]              mispred_cnt_q, mispred_cnt_d;

  logic [IDX-1:0]           d_idx;
  logic                     pred_taken;
  logic                     d_redirect;
  logic                     e_taken;
  logic                     e_is_cond;
  logic                     e_is_jalr;
  logic                     e_mispred;
  logic                     e_redirect;
  logic [XLEN-1:0]          jalr_sum;
  logic [XLEN-1:0]          e_target;
  logic [1:0]               e_ctr, e_ctr_next;

  assign d_idx = bus.pc_d[IDX+1:2];

  // With static prediction the table is still trained but never consulted.
  generate
    if (PREDICT_EN) begin : g_dyn_pred
      assign pred_taken = bus.valid_d & bus.is_branch_d & bht_q[{d_idx, 1'b1}];
    end else begin : g_static_pred
      assign pred_taken = 1'b0;
    end
  endgenerate

  assign d_redirect = ~bus.stallD & bus.valid_d & (bus.is_jal_d | pred_taken);

  // Flags come from rs1-rs2; C is the no-borrow carry.
  always_comb begin
    e_taken = 1'b0;
    case (e_func3_q)
      3'b000:  e_taken = bus.Z;
      3'b001:  e_taken = ~bus.Z;
      3'b100:  e_taken = bus.N ^ bus.V;
      3'b101:  e_taken = ~(bus.N ^ bus.V);
      3'b110:  e_taken = ~bus.C;
      3'b111:  e_taken = bus.C;
      default: e_taken = 1'b0;
    endcase
  end

  assign e_is_cond  = e_valid_q & e_branch_q;
  assign e_is_jalr  = e_valid_q & e_jalr_q;
  assign e_mispred  = e_is_cond & (e_taken ^ e_pred_q);
  assign e_redirect = e_is_jalr | e_mispred;
  assign jalr_sum   = bus.rs1_e + e_imm_q;

  always_comb begin
    e_target = e_pc_q + FOUR;
    if (e_is_jalr) begin
      e_target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (e_taken) begin
      e_target = e_pc_q + e_imm_q;
    end
  end

  // Execute redirect outranks decode redirect, which outranks a fetch stall.
  always_comb begin
    fetch_pc_d = fetch_pc_q + FOUR;
    if (e_redirect) begin
      fetch_pc_d = e_target;
    end else if (d_redirect) begin
      fetch_pc_d = bus.pc_d + bus.imm_d;
    end else if (bus.stallF) begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_comb begin
    e_valid_d  = ~bus.stallD & bus.valid_d & ~e_redirect;
    e_branch_d = e_branch_q;
    e_jalr_d   = e_jalr_q;
    e_func3_d  = e_func3_q;
    e_pred_d   = e_pred_q;
    e_idx_d    = e_idx_q;
    e_pc_d     = e_pc_q;
    e_imm_d    = e_imm_q;
    if (!bus.stallD) begin
      e_branch_d = bus.is_branch_d;
      e_jalr_d   = bus.is_jalr_d;
      e_func3_d  = bus.func3_d;
      e_pred_d   = pred_taken;
      e_idx_d    = d_idx;
      e_pc_d     = bus.pc_d;
      e_imm_d    = bus.imm_d;
    end
  end

  always_comb begin
    e_ctr      = bht_q[{e_idx_q, 1'b0} +: 2];
    e_ctr_next = e_ctr;
    if (e_taken && (e_ctr != 2'b11)) begin
      e_ctr_next = e_ctr + 2'b01;
    end else if (!e_taken && (e_ctr != 2'b00)) begin
      e_ctr_next = e_ctr - 2'b01;
    end
    bht_d = bht_q;
    if (e_is_cond) begin
      bht_d[{e_idx_q, 1'b0} +: 2] = e_ctr_next;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q + {31'd0, e_is_cond};
    mispred_cnt_d = mispred_cnt_q + {31'd0, e_mispred};
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      bht_q         <= {BHT_ENTRIES{2'b01}};
      e_valid_q     <= 1'b0;
      e_branch_q    <= 1'b0;
      e_jalr_q      <= 1'b0;
      e_func3_q     <= 3'b000;
      e_pred_q      <= 1'b0;
      e_idx_q       <= '0;
      e_pc_q        <= '0;
      e_imm_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      bht_q         <= bht_d;
      e_valid_q     <= e_valid_d;
      e_branch_q    <= e_branch_d;
      e_jalr_q      <= e_jalr_d;
      e_func3_q     <= e_func3_d;
      e_pred_q      <= e_pred_d;
      e_idx_q       <= e_idx_d;
      e_pc_q        <= e_pc_d;
      e_imm_q       <= e_imm_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Flushes are held low while in reset even if decode presents a jump.
  assign bus.pc_o           = fetch_pc_q;
  assign bus.pc_plus4_o     = fetch_pc_q + FOUR;
  assign bus.flushE_o       = rst_ni & e_redirect;
  assign bus.flushD_o       = rst_ni & (e_redirect | d_redirect);
  assign bus.pred_taken_d_o = pred_taken;
  assign bus.branch_cnt_o   = branch_cnt_q;
  assign bus.mispred_cnt_o  = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Bench for branch_pred_unit: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of fetch/predict/resolve.
module tb_branch_pred_unit;

  logic clk = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_pred_if #(.XLEN(32)) bif ();
  branch_pred_if #(.XLEN(32)) bif2 ();

  branch_pred_unit #(.XLEN(32), .BHT_ENTRIES(64), .RESET_PC(32'h0), .PREDICT_EN(1'b1)) dut (
    .clk(clk), .rst_ni(rst_ni), .bus(bif.slave));

  branch_pred_unit #(.XLEN(32), .BHT_ENTRIES(4), .RESET_PC(32'h0), .PREDICT_EN(1'b0)) dut2 (
    .clk(clk), .rst_ni(rst_ni), .bus(bif2.slave));

  // {V,Z,C,N} of a-b, C meaning no borrow
  function automatic logic [3:0] flags_of(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    return {(a[31] != b[31]) && (diff[31] != a[31]), diff == 32'd0, a >= b, diff[31]};
  endfunction

  function automatic logic cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    bif.stallF = 0; bif.stallD = 0; bif.valid_d = 0; bif.is_branch_d = 0;
    bif.is_jal_d = 0; bif.is_jalr_d = 0; bif.pc_d = '0; bif.imm_d = '0;
    bif.func3_d = '0; {bif.V, bif.Z, bif.C, bif.N} = 4'b0; bif.rs1_e = '0;
    bif2.stallF = 0; bif2.stallD = 0; bif2.valid_d = 0; bif2.is_branch_d = 0;
    bif2.is_jal_d = 0; bif2.is_jalr_d = 0; bif2.pc_d = '0; bif2.imm_d = '0;
    bif2.func3_d = '0; {bif2.V, bif2.Z, bif2.C, bif2.N} = 4'b0; bif2.rs1_e = '0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3);
    bif.valid_d = 1; bif.is_branch_d = 1; bif.is_jal_d = 0; bif.is_jalr_d = 0;
    bif.pc_d = pc; bif.imm_d = imm; bif.func3_d = f3;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    @(negedge clk);
    bif.valid_d = 1; bif.is_jal_d = 1; bif.pc_d = 32'h100; bif.imm_d = 32'h40;
    #1;
    checks++; if (bif.pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected %h", bif.pc_o, 32'h0); end
    checks++; if (bif.flushD_o !== 1'b0) begin errors++; $display("FAIL rst_flushD: got %b expected 0", bif.flushD_o); end
    checks++; if (bif.flushE_o !== 1'b0) begin errors++; $display("FAIL rst_flushE: got %b expected 0", bif.flushE_o); end
    checks++; if (bif.branch_cnt_o !== 32'd0 || bif.mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", bif.branch_cnt_o, bif.mispred_cnt_o); end
    // push a mispredicting BEQ into E, then pull reset asynchronously mid-cycle
    @(negedge clk);
    rst_ni = 1'b1; idle(); drive_br(32'h40, 32'h20, 3'b000);
    @(negedge clk);
    idle(); {bif.V, bif.Z, bif.C, bif.N} = flags_of(32'd7, 32'd7);
    #1;
    checks++; if (bif.flushE_o !== 1'b1) begin errors++; $display("FAIL rst_pre_flushE: got %b expected 1", bif.flushE_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (bif.flushE_o !== 1'b0 || bif.flushD_o !== 1'b0) begin errors++; $display("FAIL rst_async_flush: got %b%b expected 00", bif.flushD_o, bif.flushE_o); end
    checks++; if (bif.pc_o !== 32'h0) begin errors++; $display("FAIL rst_async_pc: got %h expected %h", bif.pc_o, 32'h0); end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++; if (bif.pc_o !== 32'h0 || bif.flushE_o !== 1'b0) begin errors++; $display("FAIL rst_release: got pc %h flushE %b expected 0/0", bif.pc_o, bif.flushE_o); end
    checks++; if (bif.branch_cnt_o !== 32'd0 || bif.mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_release_cnt: got %0d/%0d expected 0/0", bif.branch_cnt_o, bif.mispred_cnt_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h4) begin errors++; $display("FAIL rst_first_fetch: got %h expected %h", bif.pc_o, 32'h4); end
  endtask

  task automatic test_idle_fetch();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bif.pc_o !== 32'(4 * i) || bif.pc_plus4_o !== 32'(4 * i + 4)) begin errors++; $display("FAIL idle_pc[%0d]: got %h/%h expected %h/%h", i, bif.pc_o, bif.pc_plus4_o, 32'(4 * i), 32'(4 * i + 4)); end
      checks++; if (bif.flushD_o !== 1'b0 || bif.flushE_o !== 1'b0) begin errors++; $display("FAIL idle_flush[%0d]: got %b%b expected 00", i, bif.flushD_o, bif.flushE_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_beq_training();
    do_reset();
    drive_br(32'h40, 32'h20, 3'b000);
    #1;
    checks++; if (bif.pred_taken_d_o !== 1'b0 || bif.flushD_o !== 1'b0) begin errors++; $display("FAIL beq1_pred: got %b flushD %b expected 0/0", bif.pred_taken_d_o, bif.flushD_o); end
    @(negedge clk);
    idle(); {bif.V, bif.Z, bif.C, bif.N} = flags_of(32'd5, 32'd5);
    #1;
    checks++; if (bif.flushE_o !== 1'b1 || bif.flushD_o !== 1'b1) begin errors++; $display("FAIL beq1_flush: got %b%b expected 11", bif.flushD_o, bif.flushE_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h60) begin errors++; $display("FAIL beq1_pc: got %h expected %h", bif.pc_o, 32'h60); end
    checks++; if (bif.branch_cnt_o !== 32'd1 || bif.mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL beq1_cnt: got %0d/%0d expected 1/1", bif.branch_cnt_o, bif.mispred_cnt_o); end
    checks++; if (dut.bht_q[33:32] !== 2'b10) begin errors++; $display("FAIL beq1_bht: got %b expected 10", dut.bht_q[33:32]); end
    // second instance: predicted taken, redirected in decode only
    drive_br(32'h40, 32'h20, 3'b000);
    #1;
    checks++; if (bif.pred_taken_d_o !== 1'b1 || bif.flushD_o !== 1'b1 || bif.flushE_o !== 1'b0) begin errors++; $display("FAIL beq2_pred: got pred %b flush %b%b expected 1/10", bif.pred_taken_d_o, bif.flushD_o, bif.flushE_o); end
    @(negedge clk);
    idle(); {bif.V, bif.Z, bif.C, bif.N} = flags_of(32'd5, 32'd5);
    #1;
    checks++; if (bif.pc_o !== 32'h60 || bif.flushE_o !== 1'b0 || bif.flushD_o !== 1'b0) begin errors++; $display("FAIL beq2_resolve: got pc %h flush %b%b expected 60/00", bif.pc_o, bif.flushD_o, bif.flushE_o); end
    @(negedge clk); #1;
    checks++; if (bif.branch_cnt_o !== 32'd2 || bif.mispred_cnt_o !== 32'd1 || dut.bht_q[33:32] !== 2'b11) begin errors++; $display("FAIL beq2_state: got %0d/%0d bht %b expected 2/1 bht 11", bif.branch_cnt_o, bif.mispred_cnt_o, dut.bht_q[33:32]); end
    // third: counter saturates
    drive_br(32'h40, 32'h20, 3'b000);
    #1;
    checks++; if (bif.pred_taken_d_o !== 1'b1) begin errors++; $display("FAIL beq3_pred: got %b expected 1", bif.pred_taken_d_o); end
    @(negedge clk);
    idle(); {bif.V, bif.Z, bif.C, bif.N} = flags_of(32'd9, 32'd9);
    #1;
    checks++; if (bif.flushE_o !== 1'b0) begin errors++; $display("FAIL beq3_flushE: got %b expected 0", bif.flushE_o); end
    @(negedge clk); #1;
    checks++; if (bif.branch_cnt_o !== 32'd3 || bif.mispred_cnt_o !== 32'd1 || dut.bht_q[33:32] !== 2'b11) begin errors++; $display("FAIL beq3_state: got %0d/%0d bht %b expected 3/1 bht 11", bif.branch_cnt_o, bif.mispred_cnt_o, dut.bht_q[33:32]); end
    // fourth: predicted taken but falls through -> pc_e+4
    drive_br(32'h40, 32'h20, 3'b000);
    @(negedge clk);
    idle(); {bif.V, bif.Z, bif.C, bif.N} = flags_of(32'd1, 32'd2);
    #1;
    checks++; if (bif.flushE_o !== 1'b1) begin errors++; $display("FAIL beq4_flushE: got %b expected 1", bif.flushE_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h44 || bif.mispred_cnt_o !== 32'd2 || dut.bht_q[33:32] !== 2'b10) begin errors++; $display("FAIL beq4_state: got pc %h mis %0d bht %b expected 44/2/10", bif.pc_o, bif.mispred_cnt_o, dut.bht_q[33:32]); end
  endtask

  task automatic test_jalr();
    do_reset();
    bif.valid_d = 1; bif.is_jalr_d = 1; bif.pc_d = 32'h80; bif.imm_d = 32'h4;
    #1;
    checks++; if (bif.flushD_o !== 1'b0 || bif.flushE_o !== 1'b0) begin errors++; $display("FAIL jalr_d_flush: got %b%b expected 00", bif.flushD_o, bif.flushE_o); end
    @(negedge clk);
    idle(); bif.rs1_e = 32'h1003;
    #1;
    checks++; if (bif.flushD_o !== 1'b1 || bif.flushE_o !== 1'b1) begin errors++; $display("FAIL jalr_e_flush: got %b%b expected 11", bif.flushD_o, bif.flushE_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h1006) begin errors++; $display("FAIL jalr_pc: got %h expected %h", bif.pc_o, 32'h1006); end
    checks++; if (bif.branch_cnt_o !== 32'd0 || bif.mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL jalr_cnt: got %0d/%0d expected 0/0", bif.branch_cnt_o, bif.mispred_cnt_o); end
  endtask

  task automatic test_e_over_d_stall();
    do_reset();
    drive_br(32'h40, 32'h20, 3'b000);
    @(negedge clk);
    idle(); {bif.V, bif.Z, bif.C, bif.N} = flags_of(32'd7, 32'd7);
    bif.stallF = 1; bif.valid_d = 1; bif.is_jal_d = 1; bif.pc_d = 32'h200; bif.imm_d = 32'h100;
    #1;
    checks++; if (bif.flushD_o !== 1'b1 || bif.flushE_o !== 1'b1) begin errors++; $display("FAIL prio_flush: got %b%b expected 11", bif.flushD_o, bif.flushE_o); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bif.pc_o !== 32'h60 || bif.mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL prio_pc: got %h mis %0d expected 60/1", bif.pc_o, bif.mispred_cnt_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h64) begin errors++; $display("FAIL prio_after: got %h expected %h", bif.pc_o, 32'h64); end
  endtask

  task automatic test_stalls();
    do_reset();
    bif.stallF = 1;
    #1;
    checks++; if (bif.pc_o !== 32'h0) begin errors++; $display("FAIL stallF_0: got %h expected 0", bif.pc_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h0) begin errors++; $display("FAIL stallF_hold: got %h expected 0", bif.pc_o); end
    bif.stallF = 0;
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h4) begin errors++; $display("FAIL stallF_release: got %h expected 4", bif.pc_o); end
    bif.stallF = 1; bif.stallD = 1; bif.valid_d = 1; bif.is_jal_d = 1; bif.pc_d = 32'h300; bif.imm_d = 32'h40;
    #1;
    checks++; if (bif.flushD_o !== 1'b0) begin errors++; $display("FAIL stallD_jal: got %b expected 0", bif.flushD_o); end
    @(negedge clk);
    bif.is_jal_d = 0; drive_br(32'h40, 32'h20, 3'b000);
    #1;
    checks++; if (bif.flushE_o !== 1'b0 || bif.flushD_o !== 1'b0) begin errors++; $display("FAIL stallD_bubble1: got %b%b expected 00", bif.flushD_o, bif.flushE_o); end
    @(negedge clk);
    idle(); {bif.V, bif.Z, bif.C, bif.N} = flags_of(32'd3, 32'd3);
    #1;
    checks++; if (bif.flushE_o !== 1'b0 || bif.pc_o !== 32'h4) begin errors++; $display("FAIL stallD_bubble2: got flushE %b pc %h expected 0/4", bif.flushE_o, bif.pc_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h8 || bif.branch_cnt_o !== 32'd0) begin errors++; $display("FAIL stallD_after: got pc %h br %0d expected 8/0", bif.pc_o, bif.branch_cnt_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    bif.valid_d = 1; bif.is_jal_d = 1; bif.pc_d = 32'hFFFF_FFF0; bif.imm_d = 32'h20;
    #1;
    checks++; if (bif.flushD_o !== 1'b1) begin errors++; $display("FAIL wrap_jal_flush: got %b expected 1", bif.flushD_o); end
    @(negedge clk);
    bif.pc_d = 32'h0; bif.imm_d = 32'hFFFF_FFFC;
    #1;
    checks++; if (bif.pc_o !== 32'h10 || bif.pc_plus4_o !== 32'h14) begin errors++; $display("FAIL wrap_target: got %h/%h expected 10/14", bif.pc_o, bif.pc_plus4_o); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bif.pc_o !== 32'hFFFF_FFFC || bif.pc_plus4_o !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h/%h expected fffffffc/0", bif.pc_o, bif.pc_plus4_o); end
    @(negedge clk); #1;
    checks++; if (bif.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", bif.pc_o); end
  endtask

  task automatic test_static_predict();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bif2.valid_d = 1; bif2.is_branch_d = 1; bif2.pc_d = 32'h10; bif2.imm_d = 32'hFFFF_FFF8; bif2.func3_d = 3'b001;
      #1;
      checks++; if (bif2.pred_taken_d_o !== 1'b0 || bif2.flushD_o !== 1'b0) begin errors++; $display("FAIL static_pred[%0d]: got %b flushD %b expected 0/0", i, bif2.pred_taken_d_o, bif2.flushD_o); end
      @(negedge clk);
      idle(); {bif2.V, bif2.Z, bif2.C, bif2.N} = flags_of(32'd1, 32'd2);
      #1;
      checks++; if (bif2.flushE_o !== 1'b1) begin errors++; $display("FAIL static_flushE[%0d]: got %b expected 1", i, bif2.flushE_o); end
      @(negedge clk);
    end
    #1;
    checks++; if (bif2.mispred_cnt_o !== 32'd3 || bif2.branch_cnt_o !== 32'd3) begin errors++; $display("FAIL static_cnt: got %0d/%0d expected 3/3", bif2.branch_cnt_o, bif2.mispred_cnt_o); end
    checks++; if (dut2.bht_q[1:0] !== 2'b11) begin errors++; $display("FAIL static_bht: got %b expected 11", dut2.bht_q[1:0]); end
    checks++; if (bif2.pc_o !== 32'h8) begin errors++; $display("FAIL static_pc: got %h expected 8", bif2.pc_o); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_bc, m_mc, m_epc, m_eimm, nxt, a, b;
    logic        m_ev, m_eb, m_ej, m_ep, taken, m_cond, mis, ejalr, ered, dred, exp_pred;
    logic [2:0]  m_ef3;
    int          m_bht[64];
    int          m_eidx, didx, kind, off;
    do_reset();
    m_pc = 32'h0; m_bc = '0; m_mc = '0; m_ev = 0; m_eb = 0; m_ej = 0; m_ep = 0;
    m_ef3 = '0; m_epc = '0; m_eimm = '0; m_eidx = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      kind = int'($urandom_range(0, 9));
      bif.stallF      = ($urandom_range(0, 7) == 0);
      bif.stallD      = ($urandom_range(0, 7) == 0);
      bif.valid_d     = ($urandom_range(0, 5) != 0);
      bif.is_branch_d = (kind < 5);
      bif.is_jal_d    = (kind == 5 || kind == 6);
      bif.is_jalr_d   = (kind == 7);
      bif.pc_d        = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      off = int'($urandom_range(0, 255)) - 128;
      bif.imm_d       = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'(off * 4);
      bif.func3_d     = 3'($urandom_range(0, 7));
      bif.rs1_e       = $urandom;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = $urandom;
        2:       b = a + 32'd1;
        default: b = a ^ 32'h8000_0000;
      endcase
      {bif.V, bif.Z, bif.C, bif.N} = flags_of(a, b);
      #1;
      didx     = int'(bif.pc_d[7:2]);
      exp_pred = bif.valid_d && bif.is_branch_d && (m_bht[didx] >= 2);
      dred     = !bif.stallD && bif.valid_d && (bif.is_jal_d || exp_pred);
      taken    = cond_taken(m_ef3, a, b);
      m_cond   = m_ev && m_eb;
      mis      = m_cond && (taken != m_ep);
      ejalr    = m_ev && m_ej;
      ered     = mis || ejalr;
      checks++; if (bif.pc_o !== m_pc || bif.pc_plus4_o !== m_pc + 32'd4) begin errors++; $display("FAIL rand_pc @%0d: got %h/%h expected %h/%h", cyc, bif.pc_o, bif.pc_plus4_o, m_pc, m_pc + 32'd4); end
      checks++; if (bif.pred_taken_d_o !== exp_pred) begin errors++; $display("FAIL rand_pred @%0d: got %b expected %b", cyc, bif.pred_taken_d_o, exp_pred); end
      checks++; if (bif.flushD_o !== (ered || dred) || bif.flushE_o !== ered) begin errors++; $display("FAIL rand_flush @%0d: got %b%b expected %b%b", cyc, bif.flushD_o, bif.flushE_o, ered || dred, ered); end
      checks++; if (bif.branch_cnt_o !== m_bc || bif.mispred_cnt_o !== m_mc) begin errors++; $display("FAIL rand_cnt @%0d: got %0d/%0d expected %0d/%0d", cyc, bif.branch_cnt_o, bif.mispred_cnt_o, m_bc, m_mc); end
      if (ejalr)         nxt = (bif.rs1_e + m_eimm) & 32'hFFFF_FFFE;
      else if (mis)      nxt = taken ? m_epc + m_eimm : m_epc + 32'd4;
      else if (dred)     nxt = bif.pc_d + bif.imm_d;
      else if (bif.stallF) nxt = m_pc;
      else               nxt = m_pc + 32'd4;
      m_pc = nxt;
      if (m_cond) begin
        m_bc = m_bc + 32'd1;
        if (taken) m_bht[m_eidx] = (m_bht[m_eidx] < 3) ? m_bht[m_eidx] + 1 : 3;
        else       m_bht[m_eidx] = (m_bht[m_eidx] > 0) ? m_bht[m_eidx] - 1 : 0;
      end
      if (mis) m_mc = m_mc + 32'd1;
      if (!bif.stallD) begin
        m_eb = bif.is_branch_d; m_ej = bif.is_jalr_d; m_ef3 = bif.func3_d;
        m_ep = exp_pred; m_eidx = didx; m_epc = bif.pc_d; m_eimm = bif.imm_d;
      end
      m_ev = !bif.stallD && bif.valid_d && !ered;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_fetch();
    test_beq_training();
    test_jalr();
    test_e_over_d_stall();
    test_stalls();
    test_wrap();
    test_static_predict();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
- REQ-001: Parameter XLEN, default 32, datapath and PC width.
- REQ-002: Parameter BHT_ENTRIES, default 64, number of 2-bit counters (power of two, 2..1024); IDX = log2(BHT_ENTRIES).
- REQ-003: Parameter RESET_PC, default 0, PC value after reset.
- REQ-004: Parameter PREDICT_EN, default 1; 1 = dynamic BHT prediction, 0 = static not-taken (BHT never read, still updated).
- REQ-005: clk  in  1  sole clock; all state on rising edge.
- REQ-006: rst_ni  in  1  reset, asynchronous, active-low.
- REQ-007: stallF  in  1  hold fetch PC.
- REQ-008: stallD  in  1  hold decode; E-stage register loads a bubble.
- REQ-009: valid_d, is_branch_d, is_jal_d, is_jalr_d  in  1 each  decode-stage qualifiers.
- REQ-010: pc_d, imm_d  in  XLEN each  decode-stage PC and sign-extended immediate.
- REQ-011: func3_d  in  3  branch condition code.
- REQ-012: V, Z, C, N  in  1 each  E-stage flags of rs1-rs2 (C = 1 when no borrow).
- REQ-013: rs1_e  in  XLEN  E-stage rs1 operand for JALR.
- REQ-014: pc_o, pc_plus4_o  out  XLEN each  fetch PC and pc_o+4.
- REQ-015: flushD_o, flushE_o  out  1 each  kill F->D and D->E pipeline registers.
- REQ-016: pred_taken_d_o  out  1  decode-stage prediction (combinational).
- REQ-017: branch_cnt_o, mispred_cnt_o  out  32 each  resolved conditional branches / mispredictions.

Function
- REQ-018: Prediction: index = pc_d[IDX+1:2]; pred_taken_d_o = valid_d & is_branch_d & PREDICT_EN & bht[index][1]; combinational, no bypass of a same-cycle update.
- REQ-019: D redirect when ~stallD & valid_d & (is_jal_d | pred_taken_d_o): target pc_d+imm_d, flushD_o=1 same cycle.
- REQ-020: D->E register (valid, is_branch, is_jalr, func3, pred_taken, index, pc, imm) loads D values when ~stallD, loads bubble (valid=0) when stallD or flushE_o.
- REQ-021: E condition: 000 Z; 001 ~Z; 100 N^V; 101 ~(N^V); 110 ~C; 111 C; 010/011 never taken.
- REQ-022: E conditional branch: mispredict = taken != pred; on mispredict redirect to pc_e+imm_e (taken) or pc_e+4 (not taken), flushD_o=1, flushE_o=1.
- REQ-023: E JALR: always redirect to (rs1_e+imm_e) with bit0 cleared, flushD_o=1, flushE_o=1; not counted as branch.
- REQ-024: Next-PC priority: E redirect > D redirect > stallF hold > pc_o+4; E redirect overrides stallF.
- REQ-025: Redirect takes effect next edge: pc_o = target one cycle after resolution; one-cycle penalty for D redirect, two for E redirect.
- REQ-026: BHT update on every valid E conditional branch: saturating increment (max 3) if taken, decrement (min 0) if not; update regardless of PREDICT_EN.
- REQ-027: branch_cnt_o +1 per valid E conditional branch; mispred_cnt_o +1 per mispredict; both wrap 0xFFFFFFFF->0.
- REQ-028: All arithmetic modulo 2^XLEN; PC+4 and targets wrap silently.
- REQ-029: Bubbles (valid=0) in E cause no redirect, no BHT update, no count.

Reset
- REQ-030: While rst_ni=0 asynchronously: pc_o=RESET_PC, every BHT entry=2'b01, E register invalid, both counters 0, flushD_o=flushE_o=0.
- REQ-031: Reset deassertion mid-operation discards all in-flight branch state; first fetch after release is RESET_PC.

Verification
- REQ-032: Reset then 4 idle cycles, stalls 0 -> pc_o = 0,4,8,12,16; no flushes.
- REQ-033: BEQ at pc_d=0x40, imm=0x20, Z=1 in E, fresh BHT -> predicted not-taken, E flush pair asserted, pc_o=0x60 next cycle, mispred_cnt_o=1, entry 16 = 2'b10.
- REQ-034: Same BEQ twice more, taken -> second predicted taken, D redirect to 0x60, flushD_o only, no mispredict; entry saturates at 2'b11 on third.
- REQ-035: JALR rs1_e=0x1003, imm=4 -> pc_o=0x1006 next cycle, flushD_o=flushE_o=1, counters unchanged.
- REQ-036: Mispredict in E coincident with JAL in D and stallF=1 -> E target wins, pc_o updates despite stall.
- REQ-037: PREDICT_EN=0, BHT_ENTRIES=4, taken loop branch x3 -> pred_taken_d_o always 0, mispred_cnt_o=3, entry saturated 2'b11.
